// File: rtl/cfg_credit_sender_if.sv
// Config-message handshake and RDI pl_cfg bus between the sideband RX FIFO,
// the credit sender and the adapter. The slave modport is the sender side.
interface cfg_credit_sender_if #(
  parameter int unsigned NC    = 32,
  parameter int unsigned CNT_W = 6
);
  logic             i_msg_valid;
  logic [63:0]      i_msg_header;
  logic [63:0]      i_msg_data;
  logic             i_msg_has_data;
  logic             o_msg_ready;
  logic             i_lp_cfg_crd;
  logic [NC-1:0]    o_pl_cfg;
  logic             o_pl_cfg_vld;
  logic [CNT_W-1:0] o_credit_count;
  logic             o_crd_overflow;

  modport master (
    output i_msg_valid, i_msg_header, i_msg_data, i_msg_has_data, i_lp_cfg_crd,
    input  o_msg_ready, o_pl_cfg, o_pl_cfg_vld, o_credit_count, o_crd_overflow
  );

  modport slave (
    input  i_msg_valid, i_msg_header, i_msg_data, i_msg_has_data, i_lp_cfg_crd,
    output o_msg_ready, o_pl_cfg, o_pl_cfg_vld, o_credit_count, o_crd_overflow
  );
endinterface

// File: rtl/cfg_credit_sender.sv
// PHY-side sender of sideband config messages on the RDI pl_cfg bus.
// Serialises a 64-bit header (and optional 64-bit data word) into NC-bit
// beats, LSB beat first, and tracks the credits advertised by the adapter.
module cfg_credit_sender #(
  parameter int unsigned NC          = 32,
  parameter int unsigned MAX_CREDITS = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  cfg_credit_sender_if.slave  bus
);

  localparam int unsigned      BEATS   = 64 / NC;
  localparam int unsigned      BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]    LAST    = BW'(BEATS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CREDITS);

  typedef enum logic [1:0] {
    IDLE,
    SEND_HDR,
    SEND_DATA
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [63:0]      hdr_q, data_q;
  logic             has_data_q;
  logic [NC-1:0]    cfg_q, cfg_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ready;
  logic             accept;

  function automatic logic [NC-1:0] beat_of(input logic [63:0] w, input logic [BW-1:0] idx);
    return w[idx*NC +: NC];
  endfunction

  assign ready  = (state_q == IDLE) && (cnt_q != '0);
  assign accept = bus.i_msg_valid && ready;

  // Next state, beat index and next registered beat. The beat register is
  // loaded from the state being entered, so beat 0 is visible the cycle after
  // acceptance and the beats of one message stay contiguous.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    vld_d   = 1'b0;
    cfg_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND_HDR;
          beat_d  = '0;
          vld_d   = 1'b1;
          cfg_d   = beat_of(bus.i_msg_header, '0);
        end
      end
      SEND_HDR: begin
        if (beat_q == LAST) begin
          beat_d = '0;
          if (has_data_q) begin
            state_d = SEND_DATA;
            vld_d   = 1'b1;
            cfg_d   = beat_of(data_q, '0);
          end else begin
            state_d = IDLE;
          end
        end else begin
          beat_d = beat_q + 1'b1;
          vld_d  = 1'b1;
          cfg_d  = beat_of(hdr_q, beat_q + 1'b1);
        end
      end
      SEND_DATA: begin
        if (beat_q == LAST) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
          vld_d  = 1'b1;
          cfg_d  = beat_of(data_q, beat_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit counter: consume on accept, return on crd, saturate at the maximum.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (accept && !bus.i_lp_cfg_crd) begin
      cnt_d = cnt_q - 1'b1;
    end else if (!accept && bus.i_lp_cfg_crd) begin
      if (cnt_q == MAX_CNT) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  // FSM state, beat counter and registered pl_cfg outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cfg_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cfg_q   <= cfg_d;
      vld_q   <= vld_d;
    end
  end

  // Message latch, loaded when the FIFO entry is popped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hdr_q      <= '0;
      data_q     <= '0;
      has_data_q <= 1'b0;
    end else if (accept) begin
      hdr_q      <= bus.i_msg_header;
      data_q     <= bus.i_msg_data;
      has_data_q <= bus.i_msg_has_data;
    end
  end

  // Credit count and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= MAX_CNT;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.o_msg_ready    = ready;
  assign bus.o_pl_cfg       = cfg_q;
  assign bus.o_pl_cfg_vld   = vld_q;
  assign bus.o_credit_count = cnt_q;
  assign bus.o_crd_overflow = ovf_q;

endmodule

// File: tb/tb_cfg_credit_sender.sv
// Bench for cfg_credit_sender: two instances (NC=32/32 credits and
// NC=16/2 credits) checked every cycle against a beat-position model,
// plus directed literal expectations.
module tb_cfg_credit_sender;

  localparam int unsigned NC_A  = 32;
  localparam int unsigned MAX_A = 32;
  localparam int unsigned NC_B  = 16;
  localparam int unsigned MAX_B = 2;
  localparam int unsigned CW    = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  logic        v      [2];
  logic [63:0] hdr_in [2];
  logic [63:0] data_in[2];
  logic        has    [2];
  logic        crd    [2];

  cfg_credit_sender_if #(.NC(NC_A), .CNT_W(CW)) if_a ();
  cfg_credit_sender_if #(.NC(NC_B), .CNT_W(CW)) if_b ();

  assign if_a.i_msg_valid    = v[0];
  assign if_a.i_msg_header   = hdr_in[0];
  assign if_a.i_msg_data     = data_in[0];
  assign if_a.i_msg_has_data = has[0];
  assign if_a.i_lp_cfg_crd   = crd[0];
  assign if_b.i_msg_valid    = v[1];
  assign if_b.i_msg_header   = hdr_in[1];
  assign if_b.i_msg_data     = data_in[1];
  assign if_b.i_msg_has_data = has[1];
  assign if_b.i_lp_cfg_crd   = crd[1];

  cfg_credit_sender #(.NC(NC_A), .MAX_CREDITS(MAX_A), .CNT_W(CW)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_a.slave));
  cfg_credit_sender #(.NC(NC_B), .MAX_CREDITS(MAX_B), .CNT_W(CW)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_b.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A message is a list of beats; m_pos is the index of the beat visible this
  // cycle (-1 when nothing is on the bus).
  int          m_nc [2] = '{NC_A, NC_B};
  int          m_max[2] = '{MAX_A, MAX_B};
  logic [63:0] m_hdr[2];
  logic [63:0] m_data[2];
  int          m_total[2];
  int          m_pos[2];
  int          m_cnt[2];
  bit          m_ovf[2];

  function automatic bit m_ready(input int i);
    return (m_pos[i] < 0) && (m_cnt[i] != 0);
  endfunction

  function automatic bit m_acc(input int i);
    return v[i] && m_ready(i);
  endfunction

  function automatic logic [63:0] m_beat(input int i);
    int          beats;
    logic [63:0] w;
    logic [63:0] mask;
    beats = 64 / m_nc[i];
    w     = (m_pos[i] < beats) ? m_hdr[i] : m_data[i];
    w     = w >> ((m_pos[i] % beats) * m_nc[i]);
    mask  = (m_nc[i] == 64) ? '1 : ((64'd1 << m_nc[i]) - 64'd1);
    return w & mask;
  endfunction

  // Model update at the active edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pos[i] <= -1;
        m_cnt[i] <= m_max[i];
        m_ovf[i] <= 1'b0;
      end else begin
        if (m_acc(i)) begin
          m_hdr[i]   <= hdr_in[i];
          m_data[i]  <= data_in[i];
          m_total[i] <= (has[i] ? 2 : 1) * (64 / m_nc[i]);
          m_pos[i]   <= 0;
        end else if (m_pos[i] >= 0) begin
          m_pos[i] <= (m_pos[i] + 1 == m_total[i]) ? -1 : m_pos[i] + 1;
        end
        if (m_acc(i) && !crd[i]) begin
          m_cnt[i] <= m_cnt[i] - 1;
        end else if (!m_acc(i) && crd[i]) begin
          if (m_cnt[i] == m_max[i]) m_ovf[i] <= 1'b1;
          else                      m_cnt[i] <= m_cnt[i] + 1;
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_vld",   64'(if_a.o_pl_cfg_vld),   64'(m_pos[0] >= 0));
      chk("a_ready", 64'(if_a.o_msg_ready),    64'(m_ready(0)));
      chk("a_count", 64'(if_a.o_credit_count), 64'(m_cnt[0]));
      chk("a_ovf",   64'(if_a.o_crd_overflow), 64'(m_ovf[0]));
      if (m_pos[0] >= 0) chk("a_cfg", 64'(if_a.o_pl_cfg), m_beat(0));
      chk("b_vld",   64'(if_b.o_pl_cfg_vld),   64'(m_pos[1] >= 0));
      chk("b_ready", 64'(if_b.o_msg_ready),    64'(m_ready(1)));
      chk("b_count", 64'(if_b.o_credit_count), 64'(m_cnt[1]));
      chk("b_ovf",   64'(if_b.o_crd_overflow), 64'(m_ovf[1]));
      if (m_pos[1] >= 0) chk("b_cfg", 64'(if_b.o_pl_cfg), m_beat(1));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic rdy(input int i);
    return (i == 0) ? if_a.o_msg_ready : if_b.o_msg_ready;
  endfunction

  // Present a message at a falling edge; returns at the falling edge after
  // acceptance (first beat visible), with valid dropped.
  task automatic send(input int i, input logic [63:0] h, input logic [63:0] d, input logic hd);
    hdr_in[i] = h; data_in[i] = d; has[i] = hd; v[i] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (rdy(i)) begin
        @(negedge clk);
        v[i] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: inst %0d never ready within 200 cycles", i);
    v[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] e3[4] = '{32'h55667788, 32'h11223344, 32'hCCCCDDDD, 32'hAAAABBBB};

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; hdr_in[i] = '0; data_in[i] = '0; has[i] = 1'b0; crd[i] = 1'b0;
    end
    rst_n = 1'b0;
    idle(2);
    // Reset state
    chk("rst_vld",   64'(if_a.o_pl_cfg_vld),   64'd0);
    chk("rst_cfg",   64'(if_a.o_pl_cfg),       64'd0);
    chk("rst_count", 64'(if_a.o_credit_count), 64'd32);
    chk("rst_ovf",   64'(if_a.o_crd_overflow), 64'd0);
    chk("rst_count_b", 64'(if_b.o_credit_count), 64'd2);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(1);

    // Header-only message
    send(0, 64'h11223344_55667788, 64'h0, 1'b0);
    chk("t2_beat0", 64'(if_a.o_pl_cfg), 64'h55667788);
    chk("t2_vld0",  64'(if_a.o_pl_cfg_vld), 64'd1);
    chk("t2_count", 64'(if_a.o_credit_count), 64'd31);
    idle(1);
    chk("t2_beat1", 64'(if_a.o_pl_cfg), 64'h11223344);
    idle(1);
    chk("t2_idle_vld",   64'(if_a.o_pl_cfg_vld), 64'd0);
    chk("t2_idle_ready", 64'(if_a.o_msg_ready),  64'd1);

    // Header + data message
    send(0, 64'h11223344_55667788, 64'hAAAABBBB_CCCCDDDD, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("t3_beat",  64'(if_a.o_pl_cfg),     64'(e3[k]));
      chk("t3_ready", 64'(if_a.o_msg_ready),  64'd0);
      idle(1);
    end
    chk("t3_end_vld", 64'(if_a.o_pl_cfg_vld),   64'd0);
    chk("t3_count",   64'(if_a.o_credit_count), 64'd30);

    // Back-to-back header-only messages
    send(0, 64'h01234567_89ABCDEF, 64'h0, 1'b0);
    chk("t6_m1_beat0", 64'(if_a.o_pl_cfg), 64'h89ABCDEF);
    send(0, 64'hFEDCBA98_76543210, 64'h0, 1'b0);
    chk("t6_m2_beat0", 64'(if_a.o_pl_cfg), 64'h76543210);
    idle(1);
    chk("t6_m2_beat1", 64'(if_a.o_pl_cfg), 64'hFEDCBA98);
    chk("t6_count",    64'(if_a.o_credit_count), 64'd28);
    idle(1);

    // Drain credits down to 5
    for (int k = 0; k < 23; k++) send(0, {32'(k), ~32'(k)}, 64'h0, 1'b0);
    idle(2);
    chk("t5_count5", 64'(if_a.o_credit_count), 64'd5);
    // Accept and credit return in the same cycle
    hdr_in[0] = 64'h5555_AAAA_5555_AAAA; has[0] = 1'b0; v[0] = 1'b1; crd[0] = 1'b1;
    idle(1);
    v[0] = 1'b0; crd[0] = 1'b0;
    chk("t5_same_cycle", 64'(if_a.o_credit_count), 64'd5);
    chk("t5_beat0",      64'(if_a.o_pl_cfg),       64'h5555AAAA);
    idle(3);
    // Return credits up to the maximum, then one more
    for (int k = 0; k < 27; k++) begin
      crd[0] = 1'b1; idle(1); crd[0] = 1'b0; idle(1);
    end
    chk("t5_full",     64'(if_a.o_credit_count), 64'd32);
    chk("t5_no_ovf",   64'(if_a.o_crd_overflow), 64'd0);
    crd[0] = 1'b1; idle(1); crd[0] = 1'b0;
    chk("t5_sat",      64'(if_a.o_credit_count), 64'd32);
    chk("t5_ovf",      64'(if_a.o_crd_overflow), 64'd1);
    idle(4);
    chk("t5_ovf_sticky", 64'(if_a.o_crd_overflow), 64'd1);

    // Credit exhaustion on the 2-credit instance (NC=16)
    send(1, 64'h11223344_55667788, 64'h0, 1'b0);
    chk("t4_beat0", 64'(if_b.o_pl_cfg), 64'h7788);
    send(1, 64'h99AA_BBCC_DDEE_FF00, 64'h0102_0304_0506_0708, 1'b1);
    chk("t4_count0", 64'(if_b.o_credit_count), 64'd0);
    hdr_in[1] = 64'hCAFE_F00D_1234_5678; has[1] = 1'b0; v[1] = 1'b1;
    idle(12);
    chk("t4_blocked_ready", 64'(if_b.o_msg_ready),    64'd0);
    chk("t4_blocked_vld",   64'(if_b.o_pl_cfg_vld),   64'd0);
    crd[1] = 1'b1; idle(1); crd[1] = 1'b0;
    chk("t4_ret_count", 64'(if_b.o_credit_count), 64'd1);
    chk("t4_ret_ready", 64'(if_b.o_msg_ready),    64'd1);
    idle(1);
    v[1] = 1'b0;
    chk("t4_third_beat0", 64'(if_b.o_pl_cfg),       64'h5678);
    chk("t4_third_count", 64'(if_b.o_credit_count), 64'd0);
    idle(6);

    // Reset in the middle of a message
    send(0, 64'hDEAD_BEEF_0BAD_F00D, 64'h1357_9BDF_2468_ACE0, 1'b1);
    idle(1);
    rst_n = 1'b0;
    idle(2);
    chk("mid_rst_vld",   64'(if_a.o_pl_cfg_vld),   64'd0);
    chk("mid_rst_cfg",   64'(if_a.o_pl_cfg),       64'd0);
    chk("mid_rst_count", 64'(if_a.o_credit_count), 64'd32);
    chk("mid_rst_ovf",   64'(if_a.o_crd_overflow), 64'd0);
    rst_n = 1'b1;
    idle(3);
    send(0, 64'h0F0F_0F0F_F0F0_F0F0, 64'h0, 1'b0);
    chk("post_rst_beat0", 64'(if_a.o_pl_cfg), 64'hF0F0F0F0);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
